// File: rtl/jpeg_quant_pkg.sv
// Shared definitions for the JPEG coefficient quantizer.
//   SHIFT_TBL : 64-entry raster-order table of right-shift amounts (0..7)
//   state_e   : block sequencing FSM states
//   shift_of  : table lookup helper
package jpeg_quant_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no block open, next accept is index 0
    ST_RUN  = 1'b1   // block open, 0 < idx <= 63
  } state_e;

  // Row-major, entry [8*row + col].
  localparam logic [2:0] SHIFT_TBL [64] = '{
    3'd4, 3'd3, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6,
    3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd6, 3'd6,
    3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd6,
    3'd4, 3'd4, 3'd4, 3'd5, 3'd6, 3'd6, 3'd6, 3'd6,
    3'd4, 3'd4, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd6,
    3'd4, 3'd5, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd6,
    3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7,
    3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7
  };

  function automatic logic [2:0] shift_of(input logic [5:0] idx);
    return SHIFT_TBL[idx];
  endfunction

endpackage

// File: rtl/quant_shift.sv
// Combinational coefficient quantizer.
//   data_i  : signed input coefficient, W+1 bits
//   shift_i : right-shift amount 0..7
//   q_o     : quantized value, WN+1 bits
// SAT=0 returns data_i[shift+WN:shift] (plain truncation, wraps on overflow).
// SAT=1 returns floor(data_i / 2^shift) clamped to the signed WN+1 range.
module quant_shift #(
  parameter int W   = 15,
  parameter int WN  = 7,
  parameter int SAT = 0
) (
  input  logic [W:0]  data_i,
  input  logic [2:0]  shift_i,
  output logic [WN:0] q_o
);

  logic signed [W:0] shifted;
  logic [W-WN:0]     top;

  // Arithmetic shift gives floor division; its low WN+1 bits are exactly
  // the bit slice data_i[shift+WN:shift].
  assign shifted = $signed(data_i) >>> shift_i;
  assign top     = shifted[W:WN];

  always_comb begin
    q_o = shifted[WN:0];
    // The value fits in WN+1 signed bits only if all bits from WN upward
    // are copies of the sign bit.
    if ((SAT != 0) && !((&top) || !(|top))) begin
      q_o = top[W-WN] ? {1'b1, {WN{1'b0}}} : {1'b0, {WN{1'b1}}};
    end
  end

endmodule

// File: rtl/quant_seq.sv
// Streaming 8x8 block quantizer with one-deep output register.
//   clk, rst_n          : clock, async active-low reset
//   clr                 : sync clear of sequencing and output register
//   in_valid/in_ready   : input handshake; in_data coefficient, in_first = index 0
//   out_valid/out_ready : output handshake; out_data, out_idx, out_last (idx 63)
//   sync_err            : one-cycle pulse, aligned with the offending output
//   busy                : block open or output pending
//   blk_cnt             : completed blocks (wraps, survives clr)
//   dbg_state           : current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and the output register holds its
// contents while out_valid && !out_ready.
module quant_seq
  import jpeg_quant_pkg::*;
#(
  parameter int W   = 15,
  parameter int WN  = 7,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W:0]    in_data,
  input  logic          in_first,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WN:0]   out_data,
  output logic [5:0]    out_idx,
  output logic          out_last,
  output logic          sync_err,
  output logic          busy,
  output logic [15:0]   blk_cnt,
  output state_e        dbg_state
);

  state_e        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic [WN:0]   out_data_q, out_data_d;
  logic [5:0]    out_idx_q, out_idx_d;
  logic          out_last_q, out_last_d;
  logic          sync_err_q, sync_err_d;
  logic [15:0]   blk_cnt_q, blk_cnt_d;

  logic          accept;
  logic [5:0]    eff_idx;
  logic [WN:0]   q_val;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // in_first always restarts the block at index 0; idx_q is 0 in IDLE so an
  // unmarked coefficient there is also treated as index 0.
  assign eff_idx  = in_first ? 6'd0 : idx_q;

  quant_shift #(.W(W), .WN(WN), .SAT(SAT)) u_shift (
    .data_i  (in_data),
    .shift_i (shift_of(eff_idx)),
    .q_o     (q_val)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    sync_err_d  = 1'b0;
    blk_cnt_d   = blk_cnt_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clr) begin
      // Clear wins over a simultaneous accept; the coefficient is dropped.
      state_d     = ST_IDLE;
      idx_d       = 6'd0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_idx_d   = 6'd0;
      out_last_d  = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = q_val;
      out_idx_d   = eff_idx;
      out_last_d  = (eff_idx == 6'd63);
      sync_err_d  = in_first && (idx_q != 6'd0);
      idx_d       = eff_idx + 6'd1;  // 63 wraps to 0 when the block closes
      if (eff_idx == 6'd63) begin
        state_d   = ST_IDLE;
        blk_cnt_d = blk_cnt_q + 16'd1;
      end else begin
        state_d   = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 6'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 6'd0;
      out_last_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      blk_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      sync_err_q  <= sync_err_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign sync_err  = sync_err_q;
  assign blk_cnt   = blk_cnt_q;
  assign busy      = (state_q == ST_RUN) || out_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_quant_seq.sv
// Bench for quant_seq: a truncating instance and a saturating instance share
// all inputs. A reference model built from the quantization rules predicts
// every output each cycle; directed literal checks pin key values.
module tb_quant_seq;
  import jpeg_quant_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr = 1'b0, in_valid = 1'b0, in_first = 1'b0, out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, out_last, sync_err, busy;
  logic [7:0]  out_data;
  logic [5:0]  out_idx;
  logic [15:0] blk_cnt;
  state_e      dbg_state;
  logic        s_in_ready, s_out_valid, s_out_last, s_sync_err, s_busy;
  logic [7:0]  s_out_data;
  logic [5:0]  s_out_idx;
  logic [15:0] s_blk_cnt;
  state_e      s_dbg_state;

  quant_seq #(.W(15), .WN(7), .SAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_first(in_first), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .sync_err(sync_err),
    .busy(busy), .blk_cnt(blk_cnt), .dbg_state(dbg_state));

  quant_seq #(.W(15), .WN(7), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_first(in_first), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_idx(s_out_idx), .out_last(s_out_last), .sync_err(s_sync_err),
    .busy(s_busy), .blk_cnt(s_blk_cnt), .dbg_state(s_dbg_state));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // Independent copy of the quantizer shift table.
  int tbl [64] = '{4,3,3,4,5,5,6,6, 3,3,4,4,5,6,6,6, 4,4,4,5,5,6,6,6, 4,4,4,5,6,6,6,6,
                   4,4,5,6,6,7,7,6, 4,5,6,6,6,7,7,6, 5,6,6,7,7,7,7,7, 6,7,7,7,7,7,7,7};

  // floor(x / 2^s); truncated form keeps the low 8 bits, saturated form clamps.
  function automatic logic [7:0] model_q(logic [15:0] x, int s, bit sat);
    int v;
    int f;
    v = int'($signed(x));
    f = v >>> s;
    if (sat) begin
      if (f > 127)  f = 127;
      if (f < -128) f = -128;
    end
    return f[7:0];
  endfunction

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [5:0] idx;
    logic       last;
  } exp_t;

  exp_t        exp_q[$];
  int          m_pos = 0;     // index the next unmarked coefficient will take
  logic [15:0] m_blk = '0;
  logic        exp_sync = 1'b0;

  always @(negedge clk) begin
    bit   ev;
    int   ix;
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      m_pos = 0; m_blk = '0; exp_sync = 1'b0;
    end
    ev = (exp_q.size() != 0);
    chk("out_valid", out_valid, ev);
    chk("sat_out_valid", s_out_valid, ev);
    if (ev) begin
      chk("out_data", out_data, exp_q[0].d0);
      chk("sat_out_data", s_out_data, exp_q[0].d1);
      chk("out_idx", out_idx, exp_q[0].idx);
      chk("out_last", out_last, exp_q[0].last);
    end
    chk("sync_err", sync_err, exp_sync);
    chk("blk_cnt", blk_cnt, m_blk);
    chk("in_ready", in_ready, !ev || out_ready);
    chk("busy", busy, (m_pos != 0) || ev);
    chk("dbg_state", dbg_state, (m_pos != 0) ? ST_RUN : ST_IDLE);
    if (rst_n) begin
      exp_sync = 1'b0;
      if (clr) begin
        exp_q.delete();
        m_pos = 0;
      end else begin
        if (ev && out_ready) void'(exp_q.pop_front());
        if (in_valid && (!ev || out_ready)) begin
          if (in_first) begin
            if (m_pos != 0) exp_sync = 1'b1;
            ix = 0;
          end else begin
            ix = m_pos;
          end
          e.d0 = model_q(in_data, tbl[ix], 1'b0);
          e.d1 = model_q(in_data, tbl[ix], 1'b1);
          e.idx = 6'(ix);
          e.last = (ix == 63);
          exp_q.push_back(e);
          m_pos = (ix + 1) % 64;
          if (ix == 63) m_blk = m_blk + 16'd1;
        end
      end
    end
  end

  // ---------------- random backpressure ----------------
  bit rnd_bp = 1'b0;
  always @(posedge clk) begin
    if (rnd_bp) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [15:0] d, input bit f);
    int guard;
    bit acc;
    guard = 0;
    in_valid = 1'b1; in_data = d; in_first = f;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0; in_first = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input bit first);
    for (int i = from; i <= to; i++) begin
      drive(16'($urandom_range(0, 65535)), first && (i == from));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    idle(3);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    rst_n = 1'b1;
    idle(2);

    // Block 1: full-rate, literal values at idx 0, 1, 63.
    drive(16'h0120, 1'b1);
    chk("lit_idx0_data", out_data, 8'h12);
    chk("lit_idx0_idx", out_idx, 0);
    chk("lit_idx0_sat", s_out_data, 8'h12);
    drive(16'h0040, 1'b0);
    chk("lit_idx1_data", out_data, 8'h08);
    send_range(2, 62, 1'b0);
    drive(16'h4000, 1'b0);
    chk("lit_idx63_data", out_data, 8'h80);
    chk("lit_idx63_sat", s_out_data, 8'h7F);
    chk("lit_idx63_last", out_last, 1);
    chk("lit_blk1", blk_cnt, 1);
    idle(1);
    chk("lit_busy_after", busy, 0);
    chk("lit_valid_after", out_valid, 0);

    // Block 2: saturation extremes, then a 5-cycle stall at idx 20.
    drive(16'h7FFF, 1'b1);
    chk("lit_7fff_trunc", out_data, 8'hFF);
    chk("lit_7fff_sat", s_out_data, 8'h7F);
    drive(16'h8000, 1'b0);
    chk("lit_8000_sat", s_out_data, 8'h80);
    chk("lit_8000_trunc", out_data, 8'h00);
    send_range(2, 20, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234; in_first = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_idx", out_idx, 20);
    end
    out_ready = 1'b1;
    drive(16'h1234, 1'b0);
    chk("lit_after_stall_idx", out_idx, 21);
    send_range(22, 63, 1'b0);
    chk("lit_blk2", blk_cnt, 2);
    idle(1);

    // Block 3: misaligned in_first at idx 10.
    send_range(0, 9, 1'b1);
    drive(16'h0100, 1'b1);
    chk("lit_sync_err", sync_err, 1);
    chk("lit_sync_idx", out_idx, 0);
    chk("lit_sync_data", out_data, 8'h10);
    idle(1);
    chk("lit_sync_pulse_end", sync_err, 0);
    send_range(1, 62, 1'b0);
    chk("lit_blk_before", blk_cnt, 2);
    drive(16'h0000, 1'b0);
    chk("lit_blk3", blk_cnt, 3);

    // Block 4: random backpressure.
    rnd_bp = 1'b1;
    send_range(0, 63, 1'b1);
    rnd_bp = 1'b0;
    idle(1);
    out_ready = 1'b1;
    idle(2);
    chk("lit_blk4", blk_cnt, 4);

    // Reset in the middle of a block.
    send_range(0, 29, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_blk", blk_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_range(0, 63, 1'b1);
    chk("lit_blk_post_rst", blk_cnt, 1);
    idle(1);

    // clr colliding with an accept, then an unmarked block from IDLE.
    send_range(0, 4, 1'b1);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'h0500;
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_blk", blk_cnt, 1);
    drive(16'h0120, 1'b0);
    chk("idle_unmarked_idx", out_idx, 0);
    chk("idle_unmarked_err", sync_err, 0);
    send_range(1, 63, 1'b0);
    chk("lit_blk_final", blk_cnt, 2);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
